ln_vec_serializer: RTL and testbench

- Output-side companion to the parallel `layernorm` block.
- Captures one full normalized vector (N elements, parallel) through a valid/ready handshake.
- Emits the vector one element per beat on a valid/ready stream, element 0 first.
- Sits between the `layernorm` output and downstream element-serial consumers, such as the projection MAC.

---
 rtl/ln_vec_serializer_if.sv | 44 ++++
 rtl/ln_vec_serializer.sv | 124 ++++++++++++
 tb/tb_ln_vec_serializer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ln_vec_serializer_if.sv
// ln_vec_serializer_if: input vector handshake and output element stream of
// the layernorm output serializer. The optional out_last signal exists only
// when LN_SER_LAST_EN is defined.
interface ln_vec_serializer_if #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int IDX_WIDTH = $clog2(N);

    logic                    in_valid;
    logic                    in_ready;
    logic [N*DATA_WIDTH-1:0] in_vec;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [IDX_WIDTH-1:0]    out_idx;
`ifdef LN_SER_LAST_EN
    logic                    out_last;

    // Producer of vectors and consumer of elements (the environment side).
    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    // The serializer itself.
    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
`else
    // Producer of vectors and consumer of elements (the environment side).
    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_data, out_idx
    );

    // The serializer itself.
    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_data, out_idx
    );
`endif
endinterface

// File: rtl/ln_vec_serializer.sv
// ln_vec_serializer: captures one parallel N-element vector from layernorm and
// replays it one element per beat, element 0 first. A new vector may be taken
// on the last beat of the current one, giving bubble-free back-to-back output.
// Optional feature macro: LN_SER_LAST_EN adds bus.out_last (last-beat flag).
module ln_vec_serializer #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ln_vec_serializer_if.slave   bus,
    output logic                 vec_done_o,
    output logic [CNT_WIDTH-1:0] vec_count_o
);
    localparam int IDX_WIDTH = $clog2(N);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] buf_q [N];
    logic [IDX_WIDTH-1:0]  idx_q;
    logic [IDX_WIDTH-1:0]  idx_d;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  vec_done_q;
    logic [CNT_WIDTH-1:0]  vec_count_q;
    logic                  out_last_q;

    logic                  in_ready;
    logic                  in_hs;
    logic                  out_hs;
    logic                  last_beat;

    // Handshake decode; in_ready opens on the last beat so the next vector
    // can follow without a bubble (combinational path from out_ready).
    // NOTE: every signal gets a value on every path here, so no latch is inferred.
    always_comb begin
        last_beat = (state_q == SEND) && (idx_q == LAST_IDX);
        in_ready  = !rst && ((state_q == IDLE) || (last_beat && bus.out_ready));
        in_hs     = bus.in_valid && in_ready;
        out_hs    = out_valid_q && bus.out_ready;
        idx_d     = idx_q + IDX_WIDTH'(1);
    end

    // Serializer FSM with registered outputs and the holding buffer.
    // NOTE: the holding buffer is only N registers and is cleared on reset so
    // that nothing from a discarded vector can ever reappear on out_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            vec_done_q  <= 1'b0;
            vec_count_q <= '0;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            vec_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_hs) begin
                        for (int i = 0; i < N; i++) begin
                            buf_q[i] <= bus.in_vec[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= bus.in_vec[0 +: DATA_WIDTH];
                        out_last_q  <= 1'b0;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (out_hs) begin
                        if (idx_q == LAST_IDX) begin
                            vec_done_q  <= 1'b1;
                            vec_count_q <= vec_count_q + CNT_WIDTH'(1);
                            idx_q       <= '0;
                            out_last_q  <= 1'b0;
                            if (in_hs) begin
                                // Back-to-back: next vector starts immediately.
                                for (int i = 0; i < N; i++) begin
                                    buf_q[i] <= bus.in_vec[i*DATA_WIDTH +: DATA_WIDTH];
                                end
                                out_data_q <= bus.in_vec[0 +: DATA_WIDTH];
                            end else begin
                                out_valid_q <= 1'b0;
                                out_data_q  <= '0;
                                state_q     <= IDLE;
                            end
                        end else begin
                            idx_q      <= idx_d;
                            out_data_q <= buf_q[idx_d];
                            out_last_q <= (idx_d == LAST_IDX);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = idx_q;
    assign vec_done_o    = vec_done_q;
    assign vec_count_o   = vec_count_q;

`ifdef LN_SER_LAST_EN
    assign bus.out_last  = out_last_q;
`else
    // Without the last-beat port the flag register is unused and optimised away.
    logic unused_last;
    assign unused_last = out_last_q;
`endif
endmodule

// File: tb/tb_ln_vec_serializer.sv
// Directed testbench for ln_vec_serializer (N=4, DATA_WIDTH=8, CNT_WIDTH=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ln_vec_serializer;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          vec_done;
    logic [CW-1:0] vec_count;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    ln_vec_serializer_if #(.N(N), .DATA_WIDTH(DW)) bus ();

    ln_vec_serializer #(.N(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .vec_done_o  (vec_done),
        .vec_count_o (vec_count)
    );

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_asserts++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 || bus.out_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_out: valid=%b data=%0d idx=%0d, want 0/0/0", bus.out_valid, bus.out_data, bus.out_idx);
        end
        n_asserts++;
        if (vec_done !== 1'b0 || vec_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: done=%b count=%0d, want 0/0", vec_done, vec_count);
        end
`ifdef LN_SER_LAST_EN
        n_asserts++;
        if (bus.out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_last: got %b want 0", bus.out_last);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
        n_asserts++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        bus.in_vec    = {8'd40, 8'd30, 8'd20, 8'd10};
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        for (int i = 0; i < N; i++) begin
            n_asserts++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(10 * (i + 1)) || bus.out_idx !== 2'(i)) begin
                n_fail++;
                $display("FAIL basic_beat%0d: valid=%b data=%0d idx=%0d, want 1/%0d/%0d",
                         i, bus.out_valid, bus.out_data, bus.out_idx, 10 * (i + 1), i);
            end
            n_asserts++;
            if (vec_done !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_early_done%0d: got %b want 0", i, vec_done);
            end
`ifdef LN_SER_LAST_EN
            n_asserts++;
            if (bus.out_last !== (i == N - 1)) begin
                n_fail++;
                $display("FAIL basic_last%0d: got %b want %b", i, bus.out_last, (i == N - 1));
            end
`endif
            @(negedge clk);
        end
        n_asserts++;
        if (vec_done !== 1'b1 || vec_count !== 16'd1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_end: done=%b count=%0d valid=%b in_ready=%b, want 1/1/0/1",
                     vec_done, vec_count, bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        n_asserts++;
        if (vec_done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: got %b want 0", vec_done);
        end
    endtask

    task automatic test_back_pressure();
        bus.in_vec    = {8'd40, 8'd30, 8'd20, 8'd10};
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        n_asserts++;
        if (bus.out_data !== 8'd10 || bus.out_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_beat0: data=%0d idx=%0d, want 10/0", bus.out_data, bus.out_idx);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            n_asserts++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd20 || bus.out_idx !== 2'd1 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stall%0d: valid=%b data=%0d idx=%0d in_ready=%b, want 1/20/1/0",
                         s, bus.out_valid, bus.out_data, bus.out_idx, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_asserts++;
        if (bus.out_data !== 8'd30 || bus.out_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_resume: data=%0d idx=%0d, want 30/2", bus.out_data, bus.out_idx);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            n_asserts++;
            if (bus.out_data !== 8'd40 || bus.out_idx !== 2'd3 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_last_stall%0d: data=%0d idx=%0d in_ready=%b, want 40/3/0",
                         s, bus.out_data, bus.out_idx, bus.in_ready);
            end
`ifdef LN_SER_LAST_EN
            n_asserts++;
            if (bus.out_last !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_last_flag%0d: got %b want 1", s, bus.out_last);
            end
`endif
        end
        bus.out_ready = 1'b1;
        #1;
        n_asserts++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_in_ready_last: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        n_asserts++;
        if (bus.out_valid !== 1'b0 || vec_done !== 1'b1 || vec_count !== 16'd2) begin
            n_fail++;
            $display("FAIL bp_end: valid=%b done=%b count=%0d, want 0/1/2", bus.out_valid, vec_done, vec_count);
        end
    endtask

    task automatic test_back_to_back();
        bus.in_vec    = {8'd4, 8'd3, 8'd2, 8'd1};
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            n_asserts++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(i + 1) || bus.out_idx !== 2'(i % N)) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: valid=%b data=%0d idx=%0d, want 1/%0d/%0d",
                         i, bus.out_valid, bus.out_data, bus.out_idx, i + 1, i % N);
            end
            if (i == N - 1) begin
                bus.in_vec   = {8'd8, 8'd7, 8'd6, 8'd5};
                bus.in_valid = 1'b1;
                #1;
                n_asserts++;
                if (bus.in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready);
                end
            end
            if (i == N) begin
                bus.in_valid = 1'b0;
                n_asserts++;
                if (vec_done !== 1'b1 || vec_count !== 16'd3) begin
                    n_fail++;
                    $display("FAIL b2b_mid_done: done=%b count=%0d, want 1/3", vec_done, vec_count);
                end
            end
            @(negedge clk);
        end
        n_asserts++;
        if (bus.out_valid !== 1'b0 || vec_count !== 16'd4) begin
            n_fail++;
            $display("FAIL b2b_end: valid=%b count=%0d, want 0/4", bus.out_valid, vec_count);
        end
    endtask

    task automatic test_input_ignored();
        logic [DW-1:0] exp_data [2*N];
        exp_data = '{8'd10, 8'd20, 8'd30, 8'd40, 8'h11, 8'h22, 8'h33, 8'h44};
        bus.in_vec    = {8'd40, 8'd30, 8'd20, 8'd10};
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            n_asserts++;
            if (bus.out_data !== exp_data[i] || bus.out_idx !== 2'(i % N)) begin
                n_fail++;
                $display("FAIL ign_beat%0d: data=%0d idx=%0d, want %0d/%0d",
                         i, bus.out_data, bus.out_idx, exp_data[i], i % N);
            end
            if (i == 1) begin
                bus.in_vec   = {8'h44, 8'h33, 8'h22, 8'h11};
                bus.in_valid = 1'b1;
                #1;
                n_asserts++;
                if (bus.in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ign_in_ready_mid: got %b want 0", bus.in_ready);
                end
            end
            if (i == N) begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_asserts++;
        if (bus.out_valid !== 1'b0 || vec_count !== 16'd6) begin
            n_fail++;
            $display("FAIL ign_end: valid=%b count=%0d, want 0/6", bus.out_valid, vec_count);
        end
    endtask

    task automatic test_reset_mid();
        bus.in_vec    = {8'd40, 8'd30, 8'd20, 8'd10};
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        repeat (2) @(negedge clk);
        n_asserts++;
        if (bus.out_data !== 8'd30 || bus.out_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL rst_pre: data=%0d idx=%0d, want 30/2", bus.out_data, bus.out_idx);
        end
        rst = 1'b1;
        #1;
        n_asserts++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'd0 || bus.out_idx !== 2'd0 || vec_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_async: valid=%b data=%0d idx=%0d count=%0d, want 0/0/0/0",
                     bus.out_valid, bus.out_data, bus.out_idx, vec_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_asserts++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_idle: in_ready=%b valid=%b, want 1/0", bus.in_ready, bus.out_valid);
        end
        bus.in_vec   = {8'd9, 8'd9, 8'd9, 8'd9};
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            n_asserts++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd9 || bus.out_idx !== 2'(i)) begin
                n_fail++;
                $display("FAIL rst_fresh%0d: valid=%b data=%0d idx=%0d, want 1/9/%0d",
                         i, bus.out_valid, bus.out_data, bus.out_idx, i);
            end
            @(negedge clk);
        end
        n_asserts++;
        if (vec_count !== 16'd1 || vec_done !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_count: count=%0d done=%b, want 1/1", vec_count, vec_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_back_to_back();
        test_input_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
